bambu_slave_port_initiator: RTL and testbench

// - Host-side initiator for the accelerator's slave memory port (S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size in, Sout_Rdata_ram/Sout_DataRdy out).
// - Converts a valid/ready command stream (single read or write) into one strobed slave-port transaction on channel 0, then returns a response.
// - Sits between the test/host loader and the top-level main, so memory can be preloaded and results read back without using the master path.

---
 rtl/bambu_slv_init_pkg.sv | 26 ++
 rtl/bambu_slv_watchdog.sv | 29 ++
 rtl/bambu_slave_port_initiator.sv | 138 +++++++++++++
 tb/tb_bambu_slave_port_initiator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bambu_slv_init_pkg.sv
// Shared types and helpers for the slave-port initiator: FSM state encoding,
// size field width and the size clamp/mask functions.
package bambu_slv_init_pkg;

    localparam int unsigned SIZE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRsp  = 2'd2
    } state_e;

    // Sizes of 0 or wider than the data path mean "full width".
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size,
                                                     input int unsigned       max_size);
        if (size == '0 || 32'(size) > max_size) begin
            return SIZE_W'(max_size);
        end
        return size;
    endfunction

    function automatic logic [31:0] size_mask(input logic [SIZE_W-1:0] size);
        return (32'd1 << size) - 32'd1;
    endfunction

endpackage

// File: rtl/bambu_slv_watchdog.sv
// Cycle counter for the REQ phase: cleared by load_i, counts while en_i is high,
// and flags expiry on the cycle whose count equals TIMEOUT-1.
module bambu_slv_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/bambu_slave_port_initiator.sv
// Host-side initiator: turns one valid/ready command into a single strobed transaction on
// slave-port channel 0 and returns a response. Optional REQ timeout: BAMBU_SLV_INIT_TIMEOUT_EN.
module bambu_slave_port_initiator
    import bambu_slv_init_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    input  logic [3:0]               cmd_size,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [N_CH-1:0]          S_oe_ram,
    output logic [N_CH-1:0]          S_we_ram,
    output logic [N_CH*ADDR_W-1:0]   S_addr_ram,
    output logic [N_CH*DATA_W-1:0]   S_Wdata_ram,
    output logic [N_CH*SIZE_W-1:0]   S_data_ram_size,
    input  logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [N_CH-1:0]          Sout_DataRdy
);

    state_e              state_q;
    logic                cmd_ready_q;
    logic                oe_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SIZE_W-1:0]   size_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                accept;
    logic                in_req;
    logic                timeout_hit;
    logic [SIZE_W-1:0]   size_clamped;
    logic [DATA_W-1:0]   rd_masked;
    logic                unused_inputs;

    assign accept       = cmd_valid && cmd_ready_q;
    assign in_req       = (state_q == StReq);
    assign size_clamped = clamp_size(cmd_size, DATA_W);
    assign rd_masked    = Sout_Rdata_ram[DATA_W-1:0] & DATA_W'(size_mask(size_q));

    // Only channel 0 is ever used; the remaining lanes are read for completeness.
    assign unused_inputs = ^{Sout_Rdata_ram, Sout_DataRdy};

`ifdef BAMBU_SLV_INIT_TIMEOUT_EN
    bambu_slv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clock),
        .rst_ni    (reset),
        .load_i    (accept),
        .en_i      (in_req),
        .expired_o (timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT, in_req};
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= StReq;
                        cmd_ready_q <= 1'b0;
                        oe_q        <= !cmd_we;
                        we_q        <= cmd_we;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        size_q      <= size_clamped;
                    end
                end
                StReq: begin
                    // Completion beats the timeout when both land on the same edge.
                    if (Sout_DataRdy[0] || timeout_hit) begin
                        state_q     <= StRsp;
                        oe_q        <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= '0;
                        wdata_q     <= '0;
                        size_q      <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !Sout_DataRdy[0];
                        rsp_rdata_q <= (Sout_DataRdy[0] && oe_q) ? rd_masked : '0;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign S_oe_ram        = N_CH'(oe_q);
    assign S_we_ram        = N_CH'(we_q);
    assign S_addr_ram      = (N_CH*ADDR_W)'(addr_q);
    assign S_Wdata_ram     = (N_CH*DATA_W)'(wdata_q);
    assign S_data_ram_size = (N_CH*SIZE_W)'(size_q);

endmodule

// File: tb/tb_bambu_slave_port_initiator.sv
// Directed bench for bambu_slave_port_initiator: vector table of single transactions plus
// hand-written sequences for back-pressure, reset mid-transaction and the REQ timeout.
module tb_bambu_slave_port_initiator;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned NC = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [AW-1:0]     cmd_addr = '0;
    logic [DW-1:0]     cmd_wdata = '0;
    logic [3:0]        cmd_size = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NC-1:0]     S_oe_ram;
    logic [NC-1:0]     S_we_ram;
    logic [NC*AW-1:0]  S_addr_ram;
    logic [NC*DW-1:0]  S_Wdata_ram;
    logic [NC*4-1:0]   S_data_ram_size;
    logic [NC*DW-1:0]  Sout_Rdata_ram = '0;
    logic [NC-1:0]     Sout_DataRdy = '0;

    int checks = 0;
    int errors = 0;

    bambu_slave_port_initiator #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .N_CH    (NC),
        .TIMEOUT (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_we          (cmd_we),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_size        (cmd_size),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    size;
        int            delay;
        logic [DW-1:0] resp;
        logic [3:0]    exp_size;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if ((S_oe_ram & S_we_ram) != '0) begin
            errors++;
            $display("FAIL oe_we_overlap: oe=0x%0h we=0x%0h, expected no common bit",
                     S_oe_ram, S_we_ram);
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] size);
        int n;
        @(negedge clock);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_size  = size;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        issue(v.we, v.addr, v.wdata, v.size);
        for (int c = 1; c <= v.delay; c++) begin
            @(negedge clock);
            chk($sformatf("v%0d c%0d oe", idx, c), 32'(S_oe_ram), v.we ? 32'd0 : 32'd1);
            chk($sformatf("v%0d c%0d we", idx, c), 32'(S_we_ram), v.we ? 32'd1 : 32'd0);
            chk($sformatf("v%0d c%0d addr", idx, c), 32'(S_addr_ram), 32'(v.addr));
            chk($sformatf("v%0d c%0d size", idx, c), 32'(S_data_ram_size), 32'(v.exp_size));
            if (v.we) chk($sformatf("v%0d c%0d wdata", idx, c), 32'(S_Wdata_ram), 32'(v.wdata));
            chk($sformatf("v%0d c%0d rsp_valid", idx, c), 32'(rsp_valid), 32'd0);
            if (c == v.delay) begin
                Sout_DataRdy   = 2'b01;
                Sout_Rdata_ram = {8'hFF, v.resp};
            end
        end
        @(posedge clock);
        #1;
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;
        @(negedge clock);
        chk($sformatf("v%0d strobes_off", idx), 32'({S_oe_ram, S_we_ram}), 32'd0);
        chk($sformatf("v%0d idle_addr", idx), 32'(S_addr_ram), 32'd0);
        chk($sformatf("v%0d idle_size", idx), 32'(S_data_ram_size), 32'd0);
        chk($sformatf("v%0d idle_wdata", idx), 32'(S_Wdata_ram), 32'd0);
        chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d rsp_rdata", idx), 32'(rsp_rdata), 32'(v.exp_rdata));
        chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'd0);
        handshake();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // we addr wdata size delay resp exp_size exp_rdata
        vecs[0] = '{1'b1, 10'h005, 8'hA5, 4'd8,  1, 8'h77, 4'd8, 8'h00};
        vecs[1] = '{1'b0, 10'h3FF, 8'h00, 4'd4,  2, 8'hFF, 4'd4, 8'h0F};
        vecs[2] = '{1'b1, 10'h100, 8'h3C, 4'd0,  1, 8'h00, 4'd8, 8'h00};
        vecs[3] = '{1'b0, 10'h2AA, 8'h00, 4'd12, 3, 8'h5A, 4'd8, 8'h5A};
        vecs[4] = '{1'b0, 10'h011, 8'h00, 4'd1,  1, 8'hFF, 4'd1, 8'h01};
        vecs[5] = '{1'b0, 10'h0C0, 8'h00, 4'd7,  1, 8'hC3, 4'd7, 8'h43};
        vecs[6] = '{1'b0, 10'h0F0, 8'h00, 4'd8,  4, 8'h81, 4'd8, 8'h81};

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst strobes", 32'({S_oe_ram, S_we_ram}), 32'd0);
        chk("rst addr", 32'(S_addr_ram), 32'd0);
        chk("rst size", 32'(S_data_ram_size), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst cmd_ready", 32'(cmd_ready), 32'd1);

        // DataRdy while idle is ignored
        Sout_DataRdy   = 2'b11;
        Sout_Rdata_ram = 16'hABCD;
        @(negedge clock);
        chk("idle_rdy rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rdy strobes", 32'({S_oe_ram, S_we_ram}), 32'd0);
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        // DataRdy on the 4th strobe cycle completes normally even with the timeout enabled
        run_vec(vecs[6], 6);

        // Back-pressure: rsp_ready low for 5 cycles with cmd_valid held high
        issue(1'b0, 10'h0AB, 8'h00, 4'd8);
        cmd_valid = 1'b1;
        @(negedge clock);
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h0096;
        @(posedge clock);
        #1;
        Sout_DataRdy   = 2'b11;
        Sout_Rdata_ram = 16'hEEEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d rsp_rdata", i), 32'(rsp_rdata), 32'h96);
            chk($sformatf("hold%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
        end
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk("gap strobe", 32'(S_oe_ram), 32'd0);
        chk("gap cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        chk("b2b strobe", 32'(S_oe_ram), 32'd1);
        chk("b2b addr", 32'(S_addr_ram), 32'h0AB);
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h0011;
        @(posedge clock);
        #1;
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;
        @(negedge clock);
        chk("b2b rsp_rdata", 32'(rsp_rdata), 32'h11);
        handshake();

        // DataRdy on channel 1 only must not complete the request
        issue(1'b0, 10'h155, 8'h00, 4'd8);
        @(negedge clock);
        Sout_DataRdy   = 2'b10;
        Sout_Rdata_ram = 16'h3344;
        @(posedge clock);
        @(negedge clock);
        chk("ch1rdy strobe", 32'(S_oe_ram), 32'd1);
        chk("ch1rdy rsp_valid", 32'(rsp_valid), 32'd0);
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h335C;
        @(posedge clock);
        #1;
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;
        @(negedge clock);
        chk("ch1rdy rsp_rdata", 32'(rsp_rdata), 32'h5C);
        handshake();

        // Reset in the 2nd REQ cycle of a read drops the transaction
        issue(1'b0, 10'h222, 8'h00, 4'd8);
        @(negedge clock);
        chk("rstreq c1 strobe", 32'(S_oe_ram), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rstreq strobes", 32'({S_oe_ram, S_we_ram}), 32'd0);
        chk("rstreq addr", 32'(S_addr_ram), 32'd0);
        chk("rstreq size", 32'(S_data_ram_size), 32'd0);
        chk("rstreq cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rstreq rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("rstreq after%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("rstreq after%0d cmd_ready", i), 32'(cmd_ready), 32'd1);
        end

`ifdef BAMBU_SLV_INIT_TIMEOUT_EN
        begin
            int n;
            issue(1'b0, 10'h0F0, 8'h00, 4'd8);
            @(negedge clock);
            n = 0;
            while (S_oe_ram[0] && n < 20) begin
                n++;
                @(negedge clock);
            end
            chk("tmo strobe_cycles", 32'(n), 32'd4);
            chk("tmo rsp_valid", 32'(rsp_valid), 32'd1);
            chk("tmo rsp_err", 32'(rsp_err), 32'd1);
            chk("tmo rsp_rdata", 32'(rsp_rdata), 32'd0);
            handshake();
        end
`else
        issue(1'b0, 10'h0F0, 8'h00, 4'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("wait%0d strobe", i), 32'(S_oe_ram), 32'd1);
            chk($sformatf("wait%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
        end
        Sout_DataRdy   = 2'b01;
        Sout_Rdata_ram = 16'h00E7;
        @(posedge clock);
        #1;
        Sout_DataRdy   = '0;
        Sout_Rdata_ram = '0;
        @(negedge clock);
        chk("wait rsp_rdata", 32'(rsp_rdata), 32'hE7);
        chk("wait rsp_err", 32'(rsp_err), 32'd0);
        handshake();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
